// File: rtl/hamming_enc_seq.sv
// Purpose: Hamming(16,11) SECDED encoder that borrows the shared 8-bit ALU for pack/parity ops.
// Latency: 7 granted ALU cycles after accept (6 with P0_EN=0); each ungranted cycle adds one.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; one IDLE bubble after.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       message handshake; msg_lsw = d7..d0, msg_msw[2:0] = d10..d8
//   alu_req/alu_gnt         shared ALU ownership; alu_op/alu_a/alu_b drive it, alu_rslt returns
//                           its combinational result in the same cycle
//   out_valid/out_ready     encoded word handshake
//   enc_lsw                 {d3,d2,d1,p4,d0,p2,p1,p0}
//   enc_msw                 {d10..d4,p8}
module hamming_enc_seq #(
  parameter int DW    = 8,
  parameter int OPW   = 4,
  parameter bit P0_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  msg_lsw,
  input  logic [DW-1:0]  msg_msw,
  output logic           alu_req,
  input  logic           alu_gnt,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_rslt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  enc_lsw,
  output logic [DW-1:0]  enc_msw
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PACK_L = 4'd1;
  localparam logic [3:0] S_PACK_H = 4'd2;
  localparam logic [3:0] S_P1     = 4'd3;
  localparam logic [3:0] S_P2     = 4'd4;
  localparam logic [3:0] S_P4     = 4'd5;
  localparam logic [3:0] S_P8     = 4'd6;
  localparam logic [3:0] S_P0     = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam logic [OPW-1:0] OP_P0     = OPW'(4'b1000);
  localparam logic [OPW-1:0] OP_P1     = OPW'(4'b1001);
  localparam logic [OPW-1:0] OP_P2     = OPW'(4'b1010);
  localparam logic [OPW-1:0] OP_P4     = OPW'(4'b1011);
  localparam logic [OPW-1:0] OP_P8     = OPW'(4'b1100);
  localparam logic [OPW-1:0] OP_PACK_L = OPW'(4'b1101);
  localparam logic [OPW-1:0] OP_PACK_H = OPW'(4'b1110);

  logic [3:0]    state;
  logic [3:0]    state_nxt;
  logic [DW-1:0] lsw_q;
  logic [DW-1:0] msw_q;
  logic [DW-1:0] enc_lsw_q;
  logic [DW-1:0] enc_msw_q;
  logic          alu_busy;

  // Only d10..d8 live in the high message byte; the rest is don't-care.
  logic msw_hi_unused;
  assign msw_hi_unused = ^msg_msw[DW-1:3];

  assign alu_busy  = (state >= S_PACK_L) && (state <= S_P0);
  // Held low while reset is asserted, not just once the state register settles.
  assign in_ready  = rst_n && (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign enc_lsw   = enc_lsw_q;
  assign enc_msw   = enc_msw_q;

  // ALU command: operands zeroed whenever the ALU is not requested.
  always_comb begin
    alu_req = alu_busy;
    alu_op  = '0;
    alu_a   = '0;
    alu_b   = '0;
    if (alu_busy) begin
      alu_a = lsw_q;
      alu_b = msw_q;
      case (state)
        S_PACK_L: alu_op = OP_PACK_L;
        S_PACK_H: alu_op = OP_PACK_H;
        S_P1:     alu_op = OP_P1;
        S_P2:     alu_op = OP_P2;
        S_P4:     alu_op = OP_P4;
        S_P8:     alu_op = OP_P8;
        S_P0: begin
          // Overall parity covers the packed codeword, so it reads the enc regs.
          alu_op = OP_P0;
          alu_a  = enc_lsw_q;
          alu_b  = enc_msw_q;
        end
        default:  alu_op = '0;
      endcase
    end
  end

  // Successor of each ALU step, taken only on a granted cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_PACK_L: state_nxt = S_PACK_H;
      S_PACK_H: state_nxt = S_P1;
      S_P1:     state_nxt = S_P2;
      S_P2:     state_nxt = S_P4;
      S_P4:     state_nxt = S_P8;
      S_P8:     state_nxt = P0_EN ? S_P0 : S_DONE;
      S_P0:     state_nxt = S_DONE;
      default:  state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lsw_q     <= '0;
      msw_q     <= '0;
      enc_lsw_q <= '0;
      enc_msw_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            lsw_q     <= msg_lsw;
            msw_q     <= {{(DW-3){1'b0}}, msg_msw[2:0]};
            enc_lsw_q <= '0;
            enc_msw_q <= '0;
            state     <= S_PACK_L;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: begin
          if (alu_busy && alu_gnt) begin
            // Pack ops write whole words; parity ops touch only their own bit.
            case (state)
              S_PACK_L: enc_lsw_q    <= alu_rslt;
              S_PACK_H: enc_msw_q    <= alu_rslt;
              S_P1:     enc_lsw_q[1] <= alu_rslt[1];
              S_P2:     enc_lsw_q[2] <= alu_rslt[2];
              S_P4:     enc_lsw_q[4] <= alu_rslt[4];
              S_P8:     enc_msw_q[0] <= alu_rslt[0];
              S_P0:     enc_lsw_q[0] <= alu_rslt[0];
              default:  enc_lsw_q    <= enc_lsw_q;
            endcase
            state <= state_nxt;
          end else if (!alu_busy) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
